// File: rtl/bus_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_mem_pkg
//  Description : Shared constants for the bus memory responder: default bus
//                widths, wait-counter width and the 2-bit FSM state codes.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_mem_pkg;

    localparam int C_AW_DEF  = 8;
    localparam int C_DW_DEF  = 8;
    localparam int C_WCNT_W  = 4;   // holds WAIT_STATES-1 for WAIT_STATES up to 15

    typedef logic [1:0] state_t;

    localparam state_t C_ST_IDLE   = 2'd0;
    localparam state_t C_ST_WAIT   = 2'd1;
    localparam state_t C_ST_ACCESS = 2'd2;
    localparam state_t C_ST_ACK    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Synchronous single-port 2^AW x DW storage with write enable
//                and a registered read port. Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_array
    import bus_mem_pkg::*;
#(
    parameter int AW = C_AW_DEF,
    parameter int DW = C_DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] r_mem [2**AW];

    // Array write port; storage deliberately survives reset
    always_ff @(posedge clk) begin
        if (en && we) begin
            r_mem[addr] <= wdata;
        end
    end

    // Registered read port, updated only by an enabled read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : bus_mem_responder
//  Description : Four-phase REQ/ACK memory responder. Captures the request,
//                inserts WAIT_STATES wait cycles, performs one array access,
//                then holds ACK (and read data for reads) until REQ drops.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_mem_responder
    import bus_mem_pkg::*;
#(
    parameter int AW          = C_AW_DEF,
    parameter int DW          = C_DW_DEF,
    parameter int WAIT_STATES = 2          // legal range 0..15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          REQ,
    input  logic          WE,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] D_IN,
    output logic [DW-1:0] D_OUT,
    output logic          D_VALID,
    output logic          ACK,
    output logic          BUSY
);

    // Counter preload; clamped so WAIT_STATES=0 does not wrap (WAIT is skipped then)
    localparam int                  C_WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [C_WCNT_W-1:0] C_WAIT_LOAD   = C_WAIT_LOAD_I[C_WCNT_W-1:0];
    localparam bit                  C_HAS_WAIT    = (WAIT_STATES > 0);

    state_t              r_state;
    logic [C_WCNT_W-1:0] r_wait_cnt;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic                r_we;

    logic                w_access;
    logic [DW-1:0]       w_rdata;
    logic                w_rd_ack;

    // Request capture, wait counting and handshake sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= C_ST_IDLE;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (REQ) begin
                        r_addr  <= ADDR;
                        r_wdata <= D_IN;
                        r_we    <= WE;
                        if (C_HAS_WAIT) begin
                            r_state    <= C_ST_WAIT;
                            r_wait_cnt <= C_WAIT_LOAD;
                        end else begin
                            r_state <= C_ST_ACCESS;
                        end
                    end
                end
                C_ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= C_ST_ACCESS;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                C_ST_ACCESS: begin
                    r_state <= C_ST_ACK;
                end
                C_ST_ACK: begin
                    // Stay acknowledged until the initiator releases REQ
                    if (!REQ) begin
                        r_state <= C_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    // The array is touched only on the edge leaving ACCESS; an async reset
    // that lands before that edge forces IDLE and so suppresses the write.
    assign w_access = (r_state == C_ST_ACCESS);

    mem_array #(
        .AW (AW),
        .DW (DW)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .en    (w_access),
        .we    (r_we),
        .addr  (r_addr),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    // Outputs decode only from state and captured registers
    assign w_rd_ack = (r_state == C_ST_ACK) && !r_we;
    assign ACK      = (r_state == C_ST_ACK);
    assign D_VALID  = w_rd_ack;
    assign D_OUT    = w_rd_ack ? w_rdata : '0;
    assign BUSY     = (r_state != C_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_mem_responder
//  Description : Self-checking bench. Two responders (WAIT_STATES=2 and 0)
//                share one initiator, so both arrays hold identical contents
//                and a single array model predicts reads for either.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_mem_responder;

    logic       clk;
    logic       rst;
    logic       REQ;
    logic       WE;
    logic [7:0] ADDR;
    logic [7:0] D_IN;

    logic [7:0] d_out2, d_out0;
    logic       d_valid2, d_valid0;
    logic       ack2, ack0;
    logic       busy2, busy0;

    bus_mem_responder #(.AW(8), .DW(8), .WAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst(rst), .REQ(REQ), .WE(WE), .ADDR(ADDR), .D_IN(D_IN),
        .D_OUT(d_out2), .D_VALID(d_valid2), .ACK(ack2), .BUSY(busy2)
    );

    bus_mem_responder #(.AW(8), .DW(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .REQ(REQ), .WE(WE), .ADDR(ADDR), .D_IN(D_IN),
        .D_OUT(d_out0), .D_VALID(d_valid0), .ACK(ack0), .BUSY(busy0)
    );

    // Selected responder for latency / data observation
    logic       use0;
    logic [7:0] dout_s;
    logic       dv_s, ack_s, busy_s;
    assign dout_s = use0 ? d_out0   : d_out2;
    assign dv_s   = use0 ? d_valid0 : d_valid2;
    assign ack_s  = use0 ? ack0     : ack2;
    assign busy_s = use0 ? busy0    : busy2;

    int vectors;
    int miscompares;

    // Reference array: value plus "has been written" flag
    logic [7:0] model [256];
    bit         valid [256];

    typedef struct {
        bit         sel0;
        bit         we;
        logic [7:0] addr;
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_both_idle();
        int n;
        n = 0;
        while ((busy0 || busy2) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("both_idle", {30'd0, busy0, busy2}, 32'd0);
    endtask

    // One complete four-phase transaction; REQ held 'hold' extra cycles in ACK
    task automatic txn(input bit sel0, input bit we_i, input logic [7:0] a,
                       input logic [7:0] d, input int hold, output logic [7:0] rd);
        int lat;
        bit got;
        use0 = sel0;
        @(negedge clk);
        REQ = 1'b1; WE = we_i; ADDR = a; D_IN = d;
        lat = 0; got = 0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ack_s) got = 1;
        end
        // counts the capture edge itself, so latency is WAIT_STATES+2 edges
        check("ack_latency", lat, sel0 ? 32'd2 : 32'd4);
        check("busy_in_ack", {31'd0, busy_s}, 32'd1);
        check("d_valid", {31'd0, dv_s}, {31'd0, !we_i});
        rd = dout_s;
        if (we_i) check("d_out_on_write", {24'd0, dout_s}, 32'd0);
        else if (valid[a]) check("read_data", {24'd0, dout_s}, {24'd0, model[a]});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("ack_held", {31'd0, ack_s}, 32'd1);
        end
        @(negedge clk);
        REQ = 1'b0;
        @(posedge clk); #1;
        check("ack_drop", {31'd0, ack_s}, 32'd0);
        check("busy_drop", {31'd0, busy_s}, 32'd0);
        check("dvalid_drop", {31'd0, dv_s}, 32'd0);
        check("dout_drop", {24'd0, dout_s}, 32'd0);
        wait_both_idle();
        if (we_i) begin
            model[a] = d;
            valid[a] = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         n;
        int         cnt0, cnt2;
        vectors = 0; miscompares = 0;
        use0 = 1'b0;
        REQ = 1'b0; WE = 1'b0; ADDR = 8'h00; D_IN = 8'h00;
        for (int i = 0; i < 256; i++) begin
            valid[i] = 1'b0;
            model[i] = 8'h00;
        end

        tbl[0] = '{sel0: 1'b0, we: 1'b1, addr: 8'h10, din: 8'hA5, exp: 8'h00};
        tbl[1] = '{sel0: 1'b0, we: 1'b0, addr: 8'h10, din: 8'h00, exp: 8'hA5};
        tbl[2] = '{sel0: 1'b1, we: 1'b1, addr: 8'hFF, din: 8'h3C, exp: 8'h00};
        tbl[3] = '{sel0: 1'b1, we: 1'b0, addr: 8'hFF, din: 8'h00, exp: 8'h3C};

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outputs_ws2", {d_out2, 5'd0, d_valid2, ack2, busy2}, 32'd0);
        check("rst_outputs_ws0", {d_out0, 5'd0, d_valid0, ack0, busy0}, 32'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 4; i++) begin
            txn(tbl[i].sel0, tbl[i].we, tbl[i].addr, tbl[i].din, 1, rd);
            if (!tbl[i].we) check("table_read", {24'd0, rd}, {24'd0, tbl[i].exp});
        end

        // Inputs changed after capture are ignored
        txn(1'b0, 1'b1, 8'h20, 8'h42, 0, rd);
        use0 = 1'b0;
        @(negedge clk);
        REQ = 1'b1; WE = 1'b1; ADDR = 8'h11; D_IN = 8'h77;
        @(posedge clk); #1;
        check("busy_in_wait", {31'd0, busy2}, 32'd1);
        check("no_ack_in_wait", {31'd0, ack2}, 32'd0);
        @(negedge clk);
        ADDR = 8'h20; D_IN = 8'h00; WE = 1'b0;
        n = 0;
        while (!ack2 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("late_change_ack", {31'd0, ack2}, 32'd1);
        @(negedge clk);
        REQ = 1'b0;
        wait_both_idle();
        model[8'h11] = 8'h77; valid[8'h11] = 1'b1;
        txn(1'b0, 1'b0, 8'h11, 8'h00, 0, rd);
        check("captured_write", {24'd0, rd}, 32'h77);
        txn(1'b1, 1'b0, 8'h20, 8'h00, 0, rd);
        check("untouched_addr", {24'd0, rd}, 32'h42);

        // REQ pulsed for a single cycle: ACK still arrives, exactly one cycle
        @(negedge clk);
        REQ = 1'b1; WE = 1'b1; ADDR = 8'h05; D_IN = 8'h5A;
        @(negedge clk);
        REQ = 1'b0;
        cnt0 = 0; cnt2 = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (ack0) cnt0++;
            if (ack2) cnt2++;
        end
        check("pulse_ack_cycles_ws2", cnt2, 32'd1);
        check("pulse_ack_cycles_ws0", cnt0, 32'd1);
        check("pulse_idle", {30'd0, busy0, busy2}, 32'd0);
        model[8'h05] = 8'h5A; valid[8'h05] = 1'b1;
        txn(1'b0, 1'b0, 8'h05, 8'h00, 0, rd);
        check("pulse_write_committed", {24'd0, rd}, 32'h5A);

        // Reset mid-transaction: WAIT for ws2, ACCESS for ws0; no write lands
        txn(1'b0, 1'b1, 8'h30, 8'h99, 0, rd);
        @(negedge clk);
        REQ = 1'b1; WE = 1'b1; ADDR = 8'h30; D_IN = 8'h11;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_ws2", {d_out2, 6'd0, ack2, busy2}, 32'd0);
        check("rst_mid_ws0", {d_out0, 6'd0, ack0, busy0}, 32'd0);
        @(negedge clk);
        REQ = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 1'b0, 8'h30, 8'h00, 0, rd);
        check("rst_no_write_ws2", {24'd0, rd}, 32'h99);
        txn(1'b1, 1'b0, 8'h30, 8'h00, 0, rd);
        check("rst_no_write_ws0", {24'd0, rd}, 32'h99);

        // Randomized traffic over a small window so reads hit written words
        for (int i = 0; i < 60; i++) begin
            bit         s, w;
            logic [7:0] a, d;
            int         h;
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 8'hF0 : 8'h00);
            d = 8'($urandom);
            h = $urandom_range(0, 2);
            txn(s, w, a, d, h, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
